ram_fifo_ctrl: RTL and testbench

//  Initiator-side controller for the dual-port block RAM (1-cycle registered read).

---
 rtl/ram_fifo_pkg.sv | 19 +
 rtl/ram_fifo_ctrl_if.sv | 20 ++
 rtl/ram_fifo_skid.sv | 76 +++++++
 rtl/ram_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_pkg.sv
// ----------------------------------------------------------------------------
// ram_fifo_pkg
// Shared constants and types for the RAM-backed FIFO controller.
//   SKID_DEPTH  : entries in the output skid buffer
//   skid_cnt_t  : occupancy of the skid buffer (0..SKID_DEPTH)
//   ptr_width() : pointer width for a given RAM address width (one extra
//                 wrap bit so full and empty can be told apart)
// ----------------------------------------------------------------------------
package ram_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [$clog2(SKID_DEPTH+1)-1:0] skid_cnt_t;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ----------------------------------------------------------------------------
// ram_fifo_ctrl_if
// Valid/ready word stream used on both sides of the FIFO controller.
//   valid : source has a word on data
//   ready : sink can take the word; transfer = valid && ready
//   data  : word, DATA_WIDTH bits
// Modports: master = stream source, slave = stream sink.
// ----------------------------------------------------------------------------
interface ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/ram_fifo_skid.sv
// ----------------------------------------------------------------------------
// ram_fifo_skid
// Two-entry FIFO that catches words coming back from the RAM read port.
// Entry 0 is the head and drives the consumer directly from a flop.
//   clk, rst  : clock, asynchronous active-low reset
//   flush     : synchronous clear, overrides fill/pop
//   fill      : write fill_data at the tail this edge
//   pop       : head consumed this edge (only when valid)
//   valid     : buffer non-empty
//   head      : entry 0
//   cnt       : occupancy 0..2
// The parent's issue rule guarantees fill never arrives when full.
// ----------------------------------------------------------------------------
module ram_fifo_skid
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output skid_cnt_t             cnt
);

  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;

  assign valid = (cnt != '0);
  assign head  = entry0;

  // NOTE: all state here is updated with <= so every branch sees the
  // pre-edge values of cnt/entry0/entry1, which is what makes the shift
  // and the tail write in the pop+fill case land in the right order.
  // NOTE: the two data entries are reset as well; they are plain flops
  // and this keeps out_data at zero after reset. The RAM array behind
  // this controller is never reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      cnt    <= '0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      unique case ({fill, pop})
        2'b10: begin
          if (cnt == '0) entry0 <= fill_data;
          else           entry1 <= fill_data;
          cnt <= cnt + skid_cnt_t'(1);
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - skid_cnt_t'(1);
        end
        2'b11: begin
          // Occupancy unchanged; new word goes behind whatever remains.
          if (cnt == skid_cnt_t'(1)) begin
            entry0 <= fill_data;
          end else begin
            entry0 <= entry1;
            entry1 <= fill_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// ram_fifo_ctrl
// Turns an external dual-port block RAM (registered read, one cycle latency)
// into a valid/ready FIFO. Words are written straight into the RAM, read
// back ahead of demand (prefetch) and parked in a 2-entry skid buffer, so a
// consumer that never stalls sees one word per cycle.
//   clk, rst   : clock, asynchronous active-low reset
//   flush      : synchronous clear of everything; same-cycle push/pop ignored
//   in_if      : producer stream (slave)
//   out_if     : consumer stream (master), data registered from skid head
//   count      : words held in RAM + read in flight + skid (max DEPTH+2)
//   ram_waddr/ram_we/ram_din  : RAM write port (ram_we is the push itself)
//   ram_raddr/ram_re/ram_dout : RAM read port, ram_dout valid a cycle
//                               after ram_re
// ----------------------------------------------------------------------------
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  ram_fifo_ctrl_if.slave        in_if,
  ram_fifo_ctrl_if.master       out_if,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [PTR_W-1:0]    ptr_t;
  typedef logic [ADDR_WIDTH:0] count_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  ptr_t                  wptr;
  ptr_t                  rptr;
  ptr_t                  ram_cnt;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  skid_cnt_t             skid_cnt;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_head;
  logic [2:0]            skid_claim;

  // Words still sitting in RAM. The extra pointer bit makes DEPTH
  // distinguishable from 0 and handles address wrap without a special case.
  assign ram_cnt = wptr - rptr;

  // Gated by rst so the producer sees no space while reset is held.
  assign in_if.ready = rst && (ram_cnt != DEPTH_P);

  assign push = in_if.valid && in_if.ready && !flush;
  assign pop  = skid_valid && out_if.ready && !flush;

  // Skid slots already spoken for after this edge: held words plus the read
  // in flight, minus the one leaving now. Issuing only while this is below
  // SKID_DEPTH is what keeps the skid from ever overflowing.
  assign skid_claim = 3'(skid_cnt) + 3'(inflight) - 3'(pop);

  assign ram_re = (ram_cnt != '0) && (skid_claim < 3'(SKID_DEPTH)) && !flush;

  // A word is readable only once wptr has moved past it, so the read and
  // write ports never touch the same address in the same cycle.
  assign ram_we    = push;
  assign ram_din   = in_if.data;
  assign ram_waddr = wptr[ADDR_WIDTH-1:0];
  assign ram_raddr = rptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      count    <= '0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      count    <= '0;
    end else begin
      if (push)   wptr <= wptr + ptr_t'(1);
      if (ram_re) rptr <= rptr + ptr_t'(1);
      inflight <= ram_re;
      count    <= count + count_t'(push) - count_t'(pop);
    end
  end

  // The read issued last cycle returns on ram_dout now; a flush this cycle
  // discards it because the skid gives flush priority over fill.
  ram_fifo_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fill      (inflight),
    .fill_data (ram_dout),
    .pop       (pop),
    .valid     (skid_valid),
    .head      (skid_head),
    .cnt       (skid_cnt)
  );

  assign out_if.valid = skid_valid;
  assign out_if.data  = skid_head;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_fifo_ctrl
// Directed bench for ram_fifo_ctrl with ADDR_WIDTH=2 (DEPTH=4) and a
// behavioural dual-port RAM (registered read, sync reset tied to !rst).
// Inputs change on the falling edge; outputs are sampled 1ns later.
// ----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [AW:0]   count;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] mem [DEPTH];

  int n_vec;
  int n_err;

  ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) in_if ();
  ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) out_if ();

  ram_fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_if     (in_if),
    .out_if    (out_if),
    .count     (count),
    .ram_waddr (ram_waddr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_raddr (ram_raddr),
    .ram_re    (ram_re),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM model: write-first is irrelevant since addresses never collide.
  always @(posedge clk) begin
    if (!rst) begin
      ram_dout <= '0;
    end else begin
      if (ram_we) mem[ram_waddr] <= ram_din;
      if (ram_re) ram_dout <= mem[ram_raddr];
    end
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    in_if.valid = 1'b1; in_if.data = 32'hDEAD_BEEF; out_if.ready = 1'b1;
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_vec++; if (in_if.ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b exp 0", in_if.ready); end
      n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b exp 0", out_if.valid); end
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", count); end
      n_vec++; if (ram_we !== 1'b0 || ram_re !== 1'b0) begin n_err++; $display("FAIL rst_ram_ctl: got we=%b re=%b exp 0/0", ram_we, ram_re); end
    end
    n_vec++; if (out_if.data !== 32'd0) begin n_err++; $display("FAIL rst_out_data: got %0h exp 0", out_if.data); end
    @(negedge clk);
    in_if.valid = 1'b0; out_if.ready = 1'b0; rst = 1'b1;
    #1;
    n_vec++; if (in_if.ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b exp 1", in_if.ready); end
    n_vec++; if (count !== 3'd0 || out_if.valid !== 1'b0) begin n_err++; $display("FAIL rst_release_state: got count=%0d valid=%b exp 0/0", count, out_if.valid); end
  endtask

  task automatic test_latency();
    // C0: push 0xA5 into an empty FIFO
    @(negedge clk); in_if.valid = 1'b1; in_if.data = 32'hA5; out_if.ready = 1'b1; #1;
    n_vec++; if (ram_we !== 1'b1 || ram_waddr !== 2'd0) begin n_err++; $display("FAIL lat_c0_write: got we=%b addr=%0d exp 1/0", ram_we, ram_waddr); end
    // C1: prefetch issued
    @(negedge clk); in_if.valid = 1'b0; #1;
    n_vec++; if (ram_re !== 1'b1 || ram_raddr !== 2'd0) begin n_err++; $display("FAIL lat_c1_re: got re=%b addr=%0d exp 1/0", ram_re, ram_raddr); end
    n_vec++; if (out_if.valid !== 1'b0 || count !== 3'd1) begin n_err++; $display("FAIL lat_c1_state: got valid=%b count=%0d exp 0/1", out_if.valid, count); end
    // C2: data on ram_dout, not yet visible
    @(negedge clk); #1;
    n_vec++; if (out_if.valid !== 1'b0 || ram_re !== 1'b0) begin n_err++; $display("FAIL lat_c2: got valid=%b re=%b exp 0/0", out_if.valid, ram_re); end
    // C3: word at the output
    @(negedge clk); #1;
    n_vec++; if (out_if.valid !== 1'b1 || out_if.data !== 32'hA5) begin n_err++; $display("FAIL lat_c3_out: got valid=%b data=%0h exp 1/a5", out_if.valid, out_if.data); end
    // C4: popped at the C3 edge
    @(negedge clk); out_if.ready = 1'b0; #1;
    n_vec++; if (out_if.valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL lat_c4_empty: got valid=%b count=%0d exp 0/0", out_if.valid, count); end
  endtask

  task automatic test_full();
    int acc = 0;
    int exp = 1;
    out_if.ready = 1'b0;
    for (int c = 0; c < 20 && acc < 6; c++) begin
      @(negedge clk); in_if.valid = 1'b1; in_if.data = acc; #1;
      if (in_if.ready) acc++;
    end
    n_vec++; if (acc !== 6) begin n_err++; $display("FAIL full_accepted: got %0d exp 6", acc); end
    // Seventh word must be refused: 4 in RAM + 2 in skid
    @(negedge clk); in_if.valid = 1'b1; in_if.data = 32'd99; #1;
    n_vec++; if (in_if.ready !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL full_refuse: got ready=%b we=%b exp 0/0", in_if.ready, ram_we); end
    n_vec++; if (count !== 3'd6) begin n_err++; $display("FAIL full_count: got %0d exp 6", count); end
    n_vec++; if (out_if.valid !== 1'b1 || out_if.data !== 32'd0) begin n_err++; $display("FAIL full_head: got valid=%b data=%0h exp 1/0", out_if.valid, out_if.data); end
    // Pop cycle: RAM still full, but the prefetch goes out now
    @(negedge clk); in_if.valid = 1'b0; out_if.ready = 1'b1; #1;
    n_vec++; if (in_if.ready !== 1'b0 || ram_re !== 1'b1) begin n_err++; $display("FAIL full_pop_cycle: got ready=%b re=%b exp 0/1", in_if.ready, ram_re); end
    // Cycle after: space visible, push word 6
    @(negedge clk); out_if.ready = 1'b0; in_if.valid = 1'b1; in_if.data = 32'd6; #1;
    n_vec++; if (in_if.ready !== 1'b1 || ram_we !== 1'b1) begin n_err++; $display("FAIL full_reopen: got ready=%b we=%b exp 1/1", in_if.ready, ram_we); end
    n_vec++; if (count !== 3'd5 || out_if.data !== 32'd1) begin n_err++; $display("FAIL full_after_pop: got count=%0d data=%0h exp 5/1", count, out_if.data); end
    for (int c = 0; c < 30 && exp <= 6; c++) begin
      @(negedge clk); in_if.valid = 1'b0; out_if.ready = 1'b1; #1;
      if (out_if.valid) begin
        n_vec++; if (out_if.data !== exp) begin n_err++; $display("FAIL full_order: got %0h exp %0h", out_if.data, exp); end
        exp++;
      end
    end
    n_vec++; if (exp !== 7) begin n_err++; $display("FAIL full_drain: got %0d words exp 6", exp - 1); end
    @(negedge clk); out_if.ready = 1'b0; #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL full_drained_count: got %0d exp 0", count); end
  endtask

  task automatic test_streaming();
    int sent = 0;
    int got = 0;
    int first = -1;
    int gaps = 0;
    for (int cyc = 0; cyc < 200 && got < 100; cyc++) begin
      @(negedge clk);
      in_if.valid = (sent < 100); in_if.data = 32'd1000 + sent; out_if.ready = 1'b1;
      #1;
      if (out_if.valid) begin
        n_vec++; if (out_if.data !== 32'd1000 + got) begin n_err++; $display("FAIL stream_data: got %0d exp %0d", out_if.data, 1000 + got); end
        if (first < 0) first = cyc;
        else if (cyc != first + got) gaps++;
        got++;
      end
      if (in_if.valid && in_if.ready) sent++;
    end
    n_vec++; if (got !== 100) begin n_err++; $display("FAIL stream_count: got %0d exp 100", got); end
    n_vec++; if (gaps !== 0) begin n_err++; $display("FAIL stream_gaps: got %0d exp 0", gaps); end
    @(negedge clk); in_if.valid = 1'b0; out_if.ready = 1'b0; #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL stream_end_count: got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    @(negedge clk); in_if.valid = 1'b1; in_if.data = 32'h77; out_if.ready = 1'b0; #1;
    n_vec++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL flush_c0_we: got %b exp 1", ram_we); end
    @(negedge clk); in_if.data = 32'h78; #1;
    n_vec++; if (ram_re !== 1'b1) begin n_err++; $display("FAIL flush_c1_re: got %b exp 1", ram_re); end
    // Flush while the read of 0x77 is returning; push/pop offered and ignored
    @(negedge clk); flush = 1'b1; in_if.data = 32'h79; out_if.ready = 1'b1; #1;
    n_vec++; if (ram_we !== 1'b0 || ram_re !== 1'b0) begin n_err++; $display("FAIL flush_ctl: got we=%b re=%b exp 0/0", ram_we, ram_re); end
    @(negedge clk); flush = 1'b0; in_if.data = 32'h11; out_if.ready = 1'b0; #1;
    n_vec++; if (count !== 3'd0 || out_if.valid !== 1'b0) begin n_err++; $display("FAIL flush_cleared: got count=%0d valid=%b exp 0/0", count, out_if.valid); end
    @(negedge clk); in_if.valid = 1'b0; #1;
    n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL flush_stale: got valid=%b data=%0h exp 0", out_if.valid, out_if.data); end
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk); #1;
      if (out_if.valid) begin
        seen = 1'b1;
        n_vec++; if (out_if.data !== 32'h11 || count !== 3'd1) begin n_err++; $display("FAIL flush_first_word: got data=%0h count=%0d exp 11/1", out_if.data, count); end
      end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL flush_timeout: got no word exp 11"); end
    @(negedge clk); out_if.ready = 1'b1;
    @(negedge clk); out_if.ready = 1'b0; #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_pop_count: got %0d exp 0", count); end
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    int unsigned seq = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      in_if.valid  = ($urandom_range(0, 99) < 55);
      in_if.data   = seq * 32'h9E37_79B1;
      out_if.ready = ($urandom_range(0, 99) < 50);
      #1;
      n_vec++; if (count !== (AW+1)'(q.size())) begin n_err++; $display("FAIL rnd_count cyc %0d: got %0d exp %0d", c, count, q.size()); end
      if (out_if.valid && out_if.ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious cyc %0d: got %0h exp none", c, out_if.data);
        end else begin
          if (out_if.data !== q[0]) begin n_err++; $display("FAIL rnd_data cyc %0d: got %0h exp %0h", c, out_if.data, q[0]); end
          void'(q.pop_front());
        end
      end
      if (in_if.valid && in_if.ready) begin
        q.push_back(in_if.data);
        seq++;
      end
    end
    for (int c = 0; c < 50 && q.size() != 0; c++) begin
      @(negedge clk); in_if.valid = 1'b0; out_if.ready = 1'b1; #1;
      if (out_if.valid) begin
        n_vec++; if (out_if.data !== q[0]) begin n_err++; $display("FAIL rnd_drain_data: got %0h exp %0h", out_if.data, q[0]); end
        void'(q.pop_front());
      end
    end
    @(negedge clk); out_if.ready = 1'b0; #1;
    n_vec++; if (q.size() != 0 || count !== 3'd0) begin n_err++; $display("FAIL rnd_drain: got left=%0d count=%0d exp 0/0", q.size(), count); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_latency();
    test_full();
    test_streaming();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
